jump_cond_unit: RTL and testbench

- Downstream consumer of the ZCSO flag register.
- Accepts conditional-jump requests from decode and evaluates the condition code against the stored flags, or against flags being written that same cycle.
- Returns a registered taken/not-taken decision and the selected next PC to fetch over a valid/ready handshake.
- Stalls while an in-flight flag-setting ALU operation has not yet written the flag register.

---
 rtl/jump_cond_pkg.sv | 39 +++
 rtl/jump_cond_eval.sv | 46 ++++
 rtl/jump_cond_unit.sv | 147 ++++++++++++++
 tb/tb_jump_cond_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_cond_pkg.sv
// Shared types and constants for the conditional-jump unit: condition codes,
// flag bit positions and FSM states.
package jump_cond_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned FLAG_W     = 4;
    localparam int unsigned COND_W     = 4;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_O = 3;

    typedef enum logic [COND_W-1:0] {
        COND_AL  = 4'h0,
        COND_NV  = 4'h1,
        COND_Z   = 4'h2,
        COND_NZ  = 4'h3,
        COND_C   = 4'h4,
        COND_NC  = 4'h5,
        COND_S   = 4'h6,
        COND_NS  = 4'h7,
        COND_O   = 4'h8,
        COND_NO  = 4'h9,
        COND_LT  = 4'hA,
        COND_GE  = 4'hB,
        COND_LE  = 4'hC,
        COND_GT  = 4'hD,
        COND_ULT = 4'hE,
        COND_ULE = 4'hF
    } cond_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FLAGS = 2'd1,
        ST_HOLD       = 2'd2
    } state_t;

endpackage

// File: rtl/jump_cond_eval.sv
// Combinational condition evaluator: maps a condition code and a ZCSO flag
// vector to a taken/not-taken decision.
module jump_cond_eval
    import jump_cond_pkg::*;
(
    input  logic [COND_W-1:0] i_cond,
    input  logic [FLAG_W-1:0] i_flags,
    output logic              o_taken_c
);

    logic w_z;
    logic w_c;
    logic w_s;
    logic w_o;
    logic w_lt;

    assign w_z  = i_flags[FLAG_Z];
    assign w_c  = i_flags[FLAG_C];
    assign w_s  = i_flags[FLAG_S];
    assign w_o  = i_flags[FLAG_O];
    assign w_lt = w_s ^ w_o;

    always_comb begin
        o_taken_c = 1'b0;
        case (cond_t'(i_cond))
            COND_AL:  o_taken_c = 1'b1;
            COND_NV:  o_taken_c = 1'b0;
            COND_Z:   o_taken_c = w_z;
            COND_NZ:  o_taken_c = ~w_z;
            COND_C:   o_taken_c = w_c;
            COND_NC:  o_taken_c = ~w_c;
            COND_S:   o_taken_c = w_s;
            COND_NS:  o_taken_c = ~w_s;
            COND_O:   o_taken_c = w_o;
            COND_NO:  o_taken_c = ~w_o;
            COND_LT:  o_taken_c = w_lt;
            COND_GE:  o_taken_c = ~w_lt;
            COND_LE:  o_taken_c = w_z | w_lt;
            COND_GT:  o_taken_c = ~w_z & ~w_lt;
            COND_ULT: o_taken_c = w_c;
            COND_ULE: o_taken_c = w_c | w_z;
            default:  o_taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/jump_cond_unit.sv
// Conditional-jump resolver: evaluates a decoded jump against forwarded ZCSO
// flags, stalling on in-flight flag writers, and hands back a registered decision.
module jump_cond_unit
    import jump_cond_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [FLAG_W-1:0] i_flags_q,
    input  logic [FLAG_W-1:0] i_flags_wr_en,
    input  logic [FLAG_W-1:0] i_flags_wr_val,
    input  logic              i_flags_pending,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [COND_W-1:0] i_req_cond,
    input  logic [ADDR_W-1:0] i_req_target,
    input  logic [ADDR_W-1:0] i_req_pc_next,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic              o_res_taken,
    output logic [ADDR_W-1:0] o_res_pc
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [COND_W-1:0]   r_cond;
    logic [ADDR_W-1:0]   r_target;
    logic [ADDR_W-1:0]   r_pc_next;
    logic                r_req_ready;
    logic                r_res_valid;
    logic                r_res_taken;
    logic [ADDR_W-1:0]   r_res_pc;

    logic [COND_W-1:0]   w_cond_nxt;
    logic [ADDR_W-1:0]   w_target_nxt;
    logic [ADDR_W-1:0]   w_pc_next_nxt;
    logic                w_req_ready_nxt;
    logic                w_res_valid_nxt;
    logic                w_res_taken_nxt;
    logic [ADDR_W-1:0]   w_res_pc_nxt;

    logic [FLAG_W-1:0]   w_flags_eff;
    logic                w_flags_ok;
    logic                w_in_idle;
    logic [COND_W-1:0]   w_eval_cond;
    logic [ADDR_W-1:0]   w_eval_target;
    logic [ADDR_W-1:0]   w_eval_pc_next;
    logic                w_taken;

    // Per-bit forwarding of flags written this cycle over the stored register.
    assign w_flags_eff = (i_flags_wr_en & i_flags_wr_val) | (~i_flags_wr_en & i_flags_q);
    assign w_flags_ok  = ~i_flags_pending | (i_flags_wr_en != '0);

    // In IDLE the live request is evaluated; in WAIT_FLAGS the latched one.
    assign w_in_idle      = (r_state == ST_IDLE);
    assign w_eval_cond    = w_in_idle ? i_req_cond    : r_cond;
    assign w_eval_target  = w_in_idle ? i_req_target  : r_target;
    assign w_eval_pc_next = w_in_idle ? i_req_pc_next : r_pc_next;

    jump_cond_eval u_eval (
        .i_cond    (w_eval_cond),
        .i_flags   (w_flags_eff),
        .o_taken_c (w_taken)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_cond      <= '0;
            r_target    <= '0;
            r_pc_next   <= '0;
            r_req_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_taken <= 1'b0;
            r_res_pc    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cond      <= w_cond_nxt;
            r_target    <= w_target_nxt;
            r_pc_next   <= w_pc_next_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_taken <= w_res_taken_nxt;
            r_res_pc    <= w_res_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_state_nxt = w_flags_ok ? ST_HOLD : ST_WAIT_FLAGS;
                end
            end
            ST_WAIT_FLAGS: begin
                if (w_flags_ok) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and latched request fields.
    always_comb begin
        w_cond_nxt      = r_cond;
        w_target_nxt    = r_target;
        w_pc_next_nxt   = r_pc_next;
        w_res_taken_nxt = r_res_taken;
        w_res_pc_nxt    = r_res_pc;
        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
        w_res_valid_nxt = (w_state_nxt == ST_HOLD);
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_cond_nxt    = i_req_cond;
                    w_target_nxt  = i_req_target;
                    w_pc_next_nxt = i_req_pc_next;
                    if (w_flags_ok) begin
                        w_res_taken_nxt = w_taken;
                        w_res_pc_nxt    = w_taken ? w_eval_target : w_eval_pc_next;
                    end
                end
            end
            ST_WAIT_FLAGS: begin
                if (w_flags_ok) begin
                    w_res_taken_nxt = w_taken;
                    w_res_pc_nxt    = w_taken ? w_eval_target : w_eval_pc_next;
                end
            end
            default: ;
        endcase
    end

    assign o_req_ready = r_req_ready;
    assign o_res_valid = r_res_valid;
    assign o_res_taken = r_res_taken;
    assign o_res_pc    = r_res_pc;

endmodule

// File: tb/tb_jump_cond_unit.sv
// Bench for jump_cond_unit: directed jump requests feed an expectation queue
// that a monitor drains on every accepted decision.
module tb_jump_cond_unit;

    localparam int unsigned AW = 16;

    typedef struct {
        logic          taken;
        logic [AW-1:0] pc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    flags_q;
    logic [3:0]    flags_wr_en;
    logic [3:0]    flags_wr_val;
    logic          flags_pending;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_cond;
    logic [AW-1:0] req_target;
    logic [AW-1:0] req_pc_next;
    logic          res_valid;
    logic          res_ready;
    logic          res_taken;
    logic [AW-1:0] res_pc;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    jump_cond_unit #(.ADDR_W(AW)) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_flags_q      (flags_q),
        .i_flags_wr_en  (flags_wr_en),
        .i_flags_wr_val (flags_wr_val),
        .i_flags_pending(flags_pending),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_cond     (req_cond),
        .i_req_target   (req_target),
        .i_req_pc_next  (req_pc_next),
        .o_res_valid    (res_valid),
        .i_res_ready    (res_ready),
        .o_res_taken    (res_taken),
        .o_res_pc       (res_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Independent truth table written from the condition-code list.
    function automatic logic ref_taken(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, s, o;
        z = f[0]; cy = f[1]; s = f[2]; o = f[3];
        case (c)
            4'd0:  return 1'b1;
            4'd1:  return 1'b0;
            4'd2:  return z;
            4'd3:  return !z;
            4'd4:  return cy;
            4'd5:  return !cy;
            4'd6:  return s;
            4'd7:  return !s;
            4'd8:  return o;
            4'd9:  return !o;
            4'd10: return s != o;
            4'd11: return s == o;
            4'd12: return z || (s != o);
            4'd13: return !z && (s == o);
            4'd14: return cy;
            default: return cy || z;
        endcase
    endfunction

    // Monitor: every accepted decision must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got taken=%0b pc=0x%0h, expected none at %0t",
                         res_taken, res_pc, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_taken", 32'(res_taken), 32'(e.taken));
                chk("res_pc",    32'(res_pc),    32'(e.pc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; the unit must be idle.
    task automatic send(input logic [3:0] c, input logic [AW-1:0] t, input logic [AW-1:0] p);
        chk("req_ready_before_send", 32'(req_ready), 32'd1);
        req_cond    = c;
        req_target  = t;
        req_pc_next = p;
        req_valid   = 1'b1;
        step();
        req_valid   = 1'b0;
    endtask

    task automatic push(input logic tk, input logic [AW-1:0] pc);
        exp_t e;
        e.taken = tk;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        flags_q       = '0;
        flags_wr_en   = '0;
        flags_wr_val  = '0;
        flags_pending = 1'b0;
        req_valid     = 1'b0;
        req_cond      = '0;
        req_target    = '0;
        req_pc_next   = '0;
        res_ready     = 1'b1;
        #12;
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_res_taken", 32'(res_taken), 32'd0);
        chk("reset_res_pc",    32'(res_pc),    32'd0);
        rst_n = 1'b1;
        step();
        chk("reset_req_ready", 32'(req_ready), 32'd1);

        // Decision from stored flags, single-cycle latency.
        flags_q = 4'b0001;
        push(1'b1, 16'h0040);
        send(4'b0010, 16'h0040, 16'h0011);
        chk("t1_latency_valid", 32'(res_valid), 32'd1);
        chk("t1_ready_in_hold", 32'(req_ready), 32'd0);
        step();
        chk("t1_back_to_idle", 32'(req_ready), 32'd1);
        chk("t1_valid_dropped", 32'(res_valid), 32'd0);

        // Same-cycle forwarding of S makes lt true; without it, lt is false.
        flags_q      = 4'b0000;
        flags_wr_en  = 4'b0100;
        flags_wr_val = 4'b0100;
        push(1'b1, 16'h0100);
        send(4'b1010, 16'h0100, 16'h0104);
        flags_wr_en  = 4'b0000;
        flags_wr_val = 4'b0000;
        step();
        push(1'b0, 16'h0124);
        send(4'b1010, 16'h0120, 16'h0124);
        step();

        // Pending-flags stall: stored Z=1 is stale, the late write clears Z.
        flags_q       = 4'b0001;
        flags_pending = 1'b1;
        push(1'b1, 16'h0200);
        send(4'b0011, 16'h0200, 16'h0202);
        for (int i = 0; i < 3; i++) begin
            chk("t3_wait_req_ready", 32'(req_ready), 32'd0);
            chk("t3_wait_res_valid", 32'(res_valid), 32'd0);
            step();
        end
        chk("t3_wait_req_ready", 32'(req_ready), 32'd0);
        chk("t3_wait_res_valid", 32'(res_valid), 32'd0);
        flags_wr_en  = 4'b1111;
        flags_wr_val = 4'b0000;
        step();
        chk("t3_valid_4th_edge", 32'(res_valid), 32'd1);
        flags_wr_en   = 4'b0000;
        flags_pending = 1'b0;
        flags_q       = 4'b0000;
        step();

        // Backpressure: result frozen, flag writes and new requests ignored.
        flags_q   = 4'b0010;
        res_ready = 1'b0;
        push(1'b1, 16'h0300);
        send(4'b1110, 16'h0300, 16'h0302);
        for (int i = 0; i < 5; i++) begin
            flags_wr_en  = 4'b1111;
            flags_wr_val = 4'b0000;
            req_valid    = 1'b1;
            req_cond     = 4'b0001;
            req_target   = 16'hFFFF;
            req_pc_next  = 16'hEEEE;
            step();
            chk("t4_hold_valid", 32'(res_valid), 32'd1);
            chk("t4_hold_taken", 32'(res_taken), 32'd1);
            chk("t4_hold_pc",    32'(res_pc),    32'h0300);
            chk("t4_hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid   = 1'b0;
        flags_wr_en = 4'b0000;
        res_ready   = 1'b1;
        step();
        chk("t4_idle_ready", 32'(req_ready), 32'd1);
        chk("t4_idle_valid", 32'(res_valid), 32'd0);

        // Reset while waiting on flags drops the request for good.
        flags_q       = 4'b0000;
        flags_pending = 1'b1;
        send(4'b0000, 16'h0400, 16'h0402);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(res_valid), 32'd0);
        chk("t5_rst_pc",    32'(res_pc),    32'd0);
        flags_pending = 1'b0;
        step();
        #2;
        rst_n = 1'b1;
        step();
        chk("t5_post_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_replay", 32'(res_valid), 32'd0);
        end

        // Sweep every code against every flag combination; odd codes forward.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                logic [3:0]    cc, ff;
                logic [AW-1:0] tg, pn;
                cc = 4'(c);
                ff = 4'(f);
                tg = 16'h1000 | AW'({cc, ff});
                pn = 16'h2000 | AW'({cc, ff});
                if (cc[0]) begin
                    flags_q      = ~ff;
                    flags_wr_en  = 4'b1111;
                    flags_wr_val = ff;
                end else begin
                    flags_q      = ff;
                    flags_wr_en  = 4'b0000;
                    flags_wr_val = ~ff;
                end
                push(ref_taken(cc, ff), ref_taken(cc, ff) ? tg : pn);
                send(cc, tg, pn);
                flags_wr_en = 4'b0000;
                step();
            end
        end

        repeat (3) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
